alu_issue_queue: RTL and testbench

//  Receiving end of the dispatch-to-ALU-queue interface: buffers instructions enqueued by the dispatch

---
 rtl/alu_issue_queue_if.sv | 37 +++
 rtl/alu_issue_queue.sv | 80 ++++++++
 tb/tb_alu_issue_queue.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_issue_queue_if.sv
// alu_issue_queue_if: dispatch, CDB and issue signals of one ALU issue queue
interface alu_issue_queue_if #(parameter int DEPTH = 4, parameter int TAG_W = 6, parameter int DATA_W = 32);
  localparam int CW = $clog2(DEPTH + 1);
  logic              flush;
  logic              disp_en;
  logic [2:0]        disp_ext;
  logic [2:0]        disp_funct3;
  logic [DATA_W-1:0] disp_op1;
  logic [TAG_W-1:0]  disp_op1_tag;
  logic              disp_op1_rdy;
  logic [DATA_W-1:0] disp_op2;
  logic [TAG_W-1:0]  disp_op2_tag;
  logic              disp_op2_rdy;
  logic [TAG_W-1:0]  disp_rd_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              queue_full;
  logic [CW-1:0]     queue_count;
  logic              issue_valid;
  logic              issue_ready;
  logic [2:0]        issue_ext;
  logic [2:0]        issue_funct3;
  logic [DATA_W-1:0] issue_op1;
  logic [DATA_W-1:0] issue_op2;
  logic [TAG_W-1:0]  issue_rd_tag;
  modport master (
    output flush, disp_en, disp_ext, disp_funct3, disp_op1, disp_op1_tag, disp_op1_rdy,
           disp_op2, disp_op2_tag, disp_op2_rdy, disp_rd_tag, cdb_valid, cdb_tag, cdb_data, issue_ready,
    input  queue_full, queue_count, issue_valid, issue_ext, issue_funct3, issue_op1, issue_op2, issue_rd_tag
  );
  modport slave (
    input  flush, disp_en, disp_ext, disp_funct3, disp_op1, disp_op1_tag, disp_op1_rdy,
           disp_op2, disp_op2_tag, disp_op2_rdy, disp_rd_tag, cdb_valid, cdb_tag, cdb_data, issue_ready,
    output queue_full, queue_count, issue_valid, issue_ext, issue_funct3, issue_op1, issue_op2, issue_rd_tag
  );
endinterface

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: collapsing ALU issue queue with CDB wakeup and oldest-ready select
module alu_issue_queue #(parameter int DEPTH = 4, parameter int TAG_W = 6, parameter int DATA_W = 32) (
  input logic clk,
  input logic rst,
  alu_issue_queue_if.slave q
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  typedef struct packed {
    logic              v;
    logic              r1;
    logic              r2;
    logic [2:0]        ext;
    logic [2:0]        f3;
    logic [TAG_W-1:0]  t1;
    logic [TAG_W-1:0]  t2;
    logic [TAG_W-1:0]  rd;
    logic [DATA_W-1:0] o1;
    logic [DATA_W-1:0] o2;
  } ent_t;
  ent_t          e_q [DEPTH];
  ent_t          e_d [DEPTH];
  ent_t          n, inc, s;
  logic [CW-1:0] cnt_q, cnt_d, cnt_a;
  logic [IW-1:0] sel;
  logic          found, fire, enq, hit1, hit2;
  assign hit1 = q.cdb_valid && q.disp_op1_tag == q.cdb_tag;
  assign hit2 = q.cdb_valid && q.disp_op2_tag == q.cdb_tag;
  assign inc = '{v: 1'b1, r1: q.disp_op1_rdy | hit1, r2: q.disp_op2_rdy | hit2,
                 ext: q.disp_ext, f3: q.disp_funct3, t1: q.disp_op1_tag, t2: q.disp_op2_tag,
                 rd: q.disp_rd_tag, o1: q.disp_op1_rdy ? q.disp_op1 : q.cdb_data,
                 o2: q.disp_op2_rdy ? q.disp_op2 : q.cdb_data};
  assign q.queue_full = cnt_q == CW'(DEPTH);
  assign enq = q.disp_en && !q.queue_full;
  assign fire = found && q.issue_ready;
  assign cnt_a = cnt_q - CW'(fire);
  assign cnt_d = q.flush ? '0 : cnt_a + CW'(enq);
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (e_q[i].v && e_q[i].r1 && e_q[i].r2) begin
        sel = IW'(i);
        found = 1'b1;
      end
  end
  // Entries at or above the issued slot slide down; wakeup and enqueue act on the shifted view
  always_comb begin
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = (fire && IW'(i) >= sel) ? ((i < DEPTH - 1) ? e_q[(i < DEPTH - 1) ? i + 1 : i] : '0) : e_q[i];
      if (q.cdb_valid && n.v && !n.r1 && n.t1 == q.cdb_tag) begin
        n.r1 = 1'b1;
        n.o1 = q.cdb_data;
      end
      if (q.cdb_valid && n.v && !n.r2 && n.t2 == q.cdb_tag) begin
        n.r2 = 1'b1;
        n.o2 = q.cdb_data;
      end
      if (enq && cnt_a == CW'(i)) n = inc;
      e_d[i] = q.flush ? '0 : n;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) e_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) e_q[i] <= e_d[i];
      cnt_q <= cnt_d;
    end
  assign s = found ? e_q[sel] : '0;
  assign q.queue_count = cnt_q;
  assign q.issue_valid = found;
  assign q.issue_ext = s.ext;
  assign q.issue_funct3 = s.f3;
  assign q.issue_op1 = s.o1;
  assign q.issue_op2 = s.o2;
  assign q.issue_rd_tag = s.rd;
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed and random stimulus scored against a queue-based reference model
module tb_alu_issue_queue;
  localparam int DEPTH = 4;
  logic clk, rst;
  int checks = 0, fails = 0;
  alu_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(6), .DATA_W(32)) ifc ();
  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(6), .DATA_W(32)) dut (.clk(clk), .rst(rst), .q(ifc));
  typedef struct {
    logic [2:0]  ext, f3;
    logic [31:0] o1, o2;
    logic [5:0]  t1, t2, rd;
    bit          r1, r2;
  } m_t;
  m_t mq[$];
  m_t ne;
  int s, n0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, x, $time);
    end
  endtask
  task automatic clear();
    ifc.flush = 0; ifc.disp_en = 0; ifc.disp_ext = 0; ifc.disp_funct3 = 0;
    ifc.disp_op1 = 0; ifc.disp_op1_tag = 0; ifc.disp_op1_rdy = 0;
    ifc.disp_op2 = 0; ifc.disp_op2_tag = 0; ifc.disp_op2_rdy = 0; ifc.disp_rd_tag = 0;
    ifc.cdb_valid = 0; ifc.cdb_tag = 0; ifc.cdb_data = 0; ifc.issue_ready = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1 clear();
  endtask
  task automatic disp(input logic [31:0] o1, input logic [5:0] t1, input bit r1,
                      input logic [31:0] o2, input logic [5:0] t2, input bit r2,
                      input logic [5:0] rd, input logic [2:0] ext);
    ifc.disp_en = 1; ifc.disp_op1 = o1; ifc.disp_op1_tag = t1; ifc.disp_op1_rdy = r1;
    ifc.disp_op2 = o2; ifc.disp_op2_tag = t2; ifc.disp_op2_rdy = r2;
    ifc.disp_rd_tag = rd; ifc.disp_ext = ext; ifc.disp_funct3 = ext ^ 3'd5;
  endtask
  task automatic cdb(input logic [5:0] t, input logic [31:0] d);
    ifc.cdb_valid = 1; ifc.cdb_tag = t; ifc.cdb_data = d;
  endtask
  // Monitor: compare presented outputs with the model, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      chk("rst_valid", ifc.issue_valid, 0);
      chk("rst_count", ifc.queue_count, 0);
    end else begin
      s = -1;
      for (int i = 0; i < mq.size(); i++) if (s < 0 && mq[i].r1 && mq[i].r2) s = i;
      chk("issue_valid", ifc.issue_valid, s >= 0);
      chk("queue_count", ifc.queue_count, mq.size());
      chk("queue_full", ifc.queue_full, mq.size() == DEPTH);
      if (s >= 0) begin
        chk("issue_op1", ifc.issue_op1, mq[s].o1);
        chk("issue_op2", ifc.issue_op2, mq[s].o2);
        chk("issue_rd_tag", ifc.issue_rd_tag, mq[s].rd);
        chk("issue_ext", ifc.issue_ext, mq[s].ext);
        chk("issue_funct3", ifc.issue_funct3, mq[s].f3);
      end
      if (ifc.flush) mq.delete();
      else begin
        n0 = mq.size();
        if (s >= 0 && ifc.issue_ready) mq.delete(s);
        for (int i = 0; i < mq.size(); i++) begin
          if (ifc.cdb_valid && !mq[i].r1 && mq[i].t1 == ifc.cdb_tag) begin mq[i].r1 = 1; mq[i].o1 = ifc.cdb_data; end
          if (ifc.cdb_valid && !mq[i].r2 && mq[i].t2 == ifc.cdb_tag) begin mq[i].r2 = 1; mq[i].o2 = ifc.cdb_data; end
        end
        if (ifc.disp_en && n0 < DEPTH) begin
          ne.ext = ifc.disp_ext; ne.f3 = ifc.disp_funct3; ne.rd = ifc.disp_rd_tag;
          ne.t1 = ifc.disp_op1_tag; ne.t2 = ifc.disp_op2_tag;
          ne.r1 = ifc.disp_op1_rdy || (ifc.cdb_valid && ifc.cdb_tag == ifc.disp_op1_tag);
          ne.r2 = ifc.disp_op2_rdy || (ifc.cdb_valid && ifc.cdb_tag == ifc.disp_op2_tag);
          ne.o1 = ifc.disp_op1_rdy ? ifc.disp_op1 : ifc.cdb_data;
          ne.o2 = ifc.disp_op2_rdy ? ifc.disp_op2 : ifc.cdb_data;
          mq.push_back(ne);
        end
      end
    end
  end
  initial begin
    rst = 1;
    clear();
    #1;
    chk("reset_valid", ifc.issue_valid, 0);
    chk("reset_count", ifc.queue_count, 0);
    chk("reset_full", ifc.queue_full, 0);
    chk("reset_op1", ifc.issue_op1, 0);
    chk("reset_rd_tag", ifc.issue_rd_tag, 0);
    @(posedge clk);
    #1 rst = 0;
    tick();
    disp(5, 0, 1, 7, 0, 1, 3, 0); tick();
    ifc.issue_ready = 1; tick();
    tick();
    disp(0, 9, 0, 2, 0, 1, 4, 1); tick();
    tick();
    cdb(9, 32'hABCD); tick();
    ifc.issue_ready = 1; tick();
    disp(0, 9, 0, 3, 0, 1, 5, 2); cdb(9, 32'hABCD); tick();
    ifc.issue_ready = 1; tick();
    for (int i = 0; i < 5; i++) begin disp(i, 0, 1, i + 10, 0, 1, i + 1, 3); tick(); end
    for (int i = 0; i < 5; i++) begin ifc.issue_ready = 1; tick(); end
    disp(0, 12, 0, 1, 0, 1, 10, 4); tick();
    disp(20, 0, 1, 21, 0, 1, 11, 5); tick();
    disp(30, 0, 1, 31, 0, 1, 12, 6); tick();
    ifc.issue_ready = 1; tick();
    ifc.issue_ready = 1; tick();
    cdb(12, 32'h1234); ifc.issue_ready = 1; tick();
    ifc.issue_ready = 1; tick();
    disp(40, 0, 1, 41, 0, 1, 13, 7); tick();
    disp(0, 20, 0, 42, 0, 1, 14, 0); tick();
    disp(43, 0, 1, 44, 0, 1, 15, 1); ifc.issue_ready = 1; tick();
    cdb(20, 32'h5555); tick();
    for (int i = 0; i < 3; i++) begin ifc.issue_ready = 1; tick(); end
    for (int i = 0; i < 3; i++) begin disp(i + 50, 0, 1, i, 0, 1, i + 20, 2); tick(); end
    ifc.flush = 1; disp(60, 0, 1, 61, 0, 1, 30, 3); ifc.issue_ready = 1; tick();
    tick();
    disp(70, 0, 1, 71, 0, 1, 31, 4); tick();
    disp(72, 0, 1, 73, 0, 1, 32, 5); tick();
    #2 rst = 1;
    #1;
    chk("async_rst_valid", ifc.issue_valid, 0);
    chk("async_rst_count", ifc.queue_count, 0);
    chk("async_rst_op1", ifc.issue_op1, 0);
    @(posedge clk);
    #1 rst = 0;
    for (int c = 0; c < 3000; c++) begin
      ifc.disp_en = 1'($urandom_range(0, 1));
      ifc.disp_ext = 3'($urandom); ifc.disp_funct3 = 3'($urandom);
      ifc.disp_op1 = $urandom; ifc.disp_op1_tag = 6'($urandom_range(0, 7)); ifc.disp_op1_rdy = 1'($urandom_range(0, 1));
      ifc.disp_op2 = $urandom; ifc.disp_op2_tag = 6'($urandom_range(0, 7)); ifc.disp_op2_rdy = 1'($urandom_range(0, 1));
      ifc.disp_rd_tag = 6'($urandom);
      ifc.cdb_valid = 1'($urandom_range(0, 1)); ifc.cdb_tag = 6'($urandom_range(0, 7)); ifc.cdb_data = $urandom;
      ifc.issue_ready = $urandom_range(0, 9) < 6;
      ifc.flush = $urandom_range(0, 49) == 0;
      tick();
    end
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
